mem_access_unit: RTL

//  Memory-stage load/store unit: sits between EX/MEM and MEM/WB registers, drives a ready-gated data bus.

---
 rtl/mem_access_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage load/store unit. Sits between the EX/MEM and MEM/WB pipeline
//   registers and drives a ready-gated, word-wide data bus.
//
//   Loads:  the byte or halfword lane is selected from the bus read word, then
//           sign- or zero-extended.
//   Stores: the store data is replicated across the byte lanes, and byte
//           strobes are generated.
//
//   StallM freezes the pipeline until each access completes. The unit never
//   writes the register file; ReadDataM feeds MEM/WB.
//
//   Configuration macro: MISALIGN_TRAP_EN
//     defined   - a misaligned H/W access issues no bus request; misalign_o
//                 pulses in DONE.
//     undefined - the offending low address bits are forced to zero;
//                 misalign_o is tied low.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   MemReadM, MemWriteM        load / store present in the MEM stage
//   funct3M                    size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM                 byte address
//   WriteDataM                 store data, right-aligned
//   flush                      discard the current MEM instruction
//   ReadDataM                  extended load data (valid in DONE)
//   StallM                     pipeline freeze request
//   mem_req/we/addr/wdata/be   bus request (registered)
//   mem_rdata, mem_ready       bus response
//   misalign_o                 misaligned-access pulse
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [2:0]       funct3M,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             flush,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    state_t           state_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [3:0]       mem_be_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic             flush_q;
    logic [WIDTH-1:0] rdata_q;
    logic             misalign_q;

    // ------------------------------------------------------------------
    // Request-side combinational decode (from the MEM-stage inputs)
    // ------------------------------------------------------------------
    logic             access_d;
    logic [1:0]       size_d;
    logic [1:0]       off_d;
    logic [3:0]       be_d;
    logic [WIDTH-1:0] wdata_d;
    logic             trap_d;

    assign access_d = MemReadM | MemWriteM;
    assign size_d   = funct3M[1:0];

`ifdef MISALIGN_TRAP_EN
    // Undefined sizes (11) count as word accesses.
    assign trap_d = ((size_d == SZ_H) && ALUResultM[0]) ||
                    (size_d[1] && (ALUResultM[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    // Effective lane offset: misaligned low bits are dropped, so a
    // halfword stays within its aligned half and a word uses all lanes.
    always_comb begin
        off_d   = 2'b00;
        be_d    = 4'b0000;
        wdata_d = WriteDataM;
        case (size_d)
            SZ_B: begin
                off_d   = ALUResultM[1:0];
                be_d    = 4'b0001 << off_d;
                wdata_d = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                off_d   = {ALUResultM[1], 1'b0};
                be_d    = 4'b0011 << off_d;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                off_d   = 2'b00;
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
        // Strobes are only meaningful for writes.
        if (!MemWriteM) begin
            be_d = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load-side lane extraction and extension (from the latched request)
    // ------------------------------------------------------------------
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WIDTH-1:0] load_ext;
    logic             sext;

    assign sext = ~funct3_q[2];

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_ext = mem_rdata;
        case (funct3_q[1:0])
            SZ_B:    load_ext = {{24{sext & byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{sext & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            flush_q     <= 1'b0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdata_q    <= '0;
                    misalign_q <= 1'b0;
                    if (access_d && !flush) begin
                        funct3_q <= funct3M;
                        off_q    <= off_d;
                        flush_q  <= 1'b0;
                        if (trap_d) begin
                            // Trapped access: skip the bus entirely.
                            misalign_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWriteM;
                            mem_addr_q  <= {ALUResultM[WIDTH-1:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_be_q    <= be_d;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A flush here cannot cancel the bus cycle; it only
                    // suppresses the load result.
                    if (flush) begin
                        flush_q <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0000;
                        if (flush_q || flush || mem_we_q) begin
                            rdata_q <= '0;
                        end else begin
                            rdata_q <= load_ext;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rdata_q    <= '0;
                    misalign_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The stall is combinational in the access cycle so the pipeline freezes
    // before the request is even registered. It is gated by reset so it drops
    // immediately when reset is asserted.
    assign StallM = rst_n &
                    (((state_q == IDLE) && access_d && !flush) ||
                     (state_q == REQ));

    assign ReadDataM  = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign misalign_o = misalign_q;

endmodule
